// File: rtl/_difetto_tap.sv
// IEEE 1149.1 TAP controller: 16-state TMS FSM, configurable instruction register,
// IDCODE/BYPASS data registers and the TDO mux for the boundary and internal scan chains.
module _difetto_tap #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE        = 32'h0000_0001,
  parameter logic        TEST_POLARITY = 1'b1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic TDO_EN,
  output logic BSR_SI,
  input  logic BSR_SO,
  input  logic SCAN_SO,
  output logic TEST,
  output logic BSR_SEL,
  output logic SCAN_SEL,
  output logic CAPTURE_DR,
  output logic SHIFT_DR,
  output logic UPDATE_DR
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_t;

  typedef enum logic [2:0] {I_EXTEST, I_IDCODE, I_SAMPLE, I_SCAN, I_BYPASS} instr_t;

  localparam logic [IR_WIDTH-1:0] CODE_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] CODE_SAMPLE  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] CODE_SCAN    = IR_WIDTH'(3);
  localparam logic [31:0]         IDCODE_VALUE = IDCODE | 32'd1;

  // All-ones is checked first so BYPASS wins even when IR_WIDTH makes it alias SCAN.
  function automatic instr_t decode(input logic [IR_WIDTH-1:0] code);
    if (&code)                    return I_BYPASS;
    else if (code == '0)          return I_EXTEST;
    else if (code == CODE_IDCODE) return I_IDCODE;
    else if (code == CODE_SAMPLE) return I_SAMPLE;
    else if (code == CODE_SCAN)   return I_SCAN;
    else                          return I_BYPASS;
  endfunction

  state_t              state, next_state;
  instr_t              instr;
  logic [IR_WIDTH-1:0] ir_shift, ir_active;
  logic [31:0]         idcode_reg;
  logic                bypass_reg;
  logic                dr_so;

  assign instr  = decode(ir_active);
  assign BSR_SI = TDI;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= TLR;
    else          state <= next_state;
  end

  // NOTE: next_state defaults to state up front so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      TLR:    next_state = TMS ? TLR    : RTI;
      RTI:    next_state = TMS ? SEL_DR : RTI;
      SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR: next_state = TMS ? UPD_DR : PA_DR;
      PA_DR:  next_state = TMS ? EX2_DR : PA_DR;
      EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR: next_state = TMS ? SEL_DR : RTI;
      SEL_IR: next_state = TMS ? TLR    : CAP_IR;
      CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR: next_state = TMS ? UPD_IR : PA_IR;
      PA_IR:  next_state = TMS ? EX2_IR : PA_IR;
      EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR: next_state = TMS ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_comb begin
    BSR_SEL    = (instr == I_EXTEST) || (instr == I_SAMPLE);
    SCAN_SEL   = (instr == I_SCAN);
    TEST       = (instr == I_EXTEST) ? TEST_POLARITY : !TEST_POLARITY;
    CAPTURE_DR = (state == CAP_DR) && (BSR_SEL || SCAN_SEL);
    SHIFT_DR   = (state == SH_DR)  && (BSR_SEL || SCAN_SEL);
    UPDATE_DR  = (state == UPD_DR) && BSR_SEL;
  end

  // Entering TLR restores IDCODE on the same edge, so TLR never sees a stale instruction.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                ir_active <= CODE_IDCODE;
    else if (next_state == TLR)  ir_active <= CODE_IDCODE;
    else if (state == UPD_IR)    ir_active <= ir_shift;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)              ir_shift <= CODE_IDCODE;
    else if (state == CAP_IR)  ir_shift <= CODE_IDCODE;
    else if (state == SH_IR)   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idcode_reg <= IDCODE_VALUE;
      bypass_reg <= 1'b0;
    end else begin
      if (instr == I_IDCODE) begin
        if (state == CAP_DR)     idcode_reg <= IDCODE_VALUE;
        else if (state == SH_DR) idcode_reg <= {TDI, idcode_reg[31:1]};
      end
      if (instr == I_BYPASS) begin
        if (state == CAP_DR)     bypass_reg <= 1'b0;
        else if (state == SH_DR) bypass_reg <= TDI;
      end
    end
  end

  always_comb begin
    unique case (instr)
      I_EXTEST, I_SAMPLE: dr_so = BSR_SO;
      I_SCAN:             dr_so = SCAN_SO;
      I_IDCODE:           dr_so = idcode_reg[0];
      default:            dr_so = bypass_reg;
    endcase
  end

  // Falling-edge TDO keeps data stable for the downstream device's rising-edge sample.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      unique case (state)
        SH_IR: begin
          TDO    <= ir_shift[0];
          TDO_EN <= 1'b1;
        end
        SH_DR: begin
          TDO    <= dr_so;
          TDO_EN <= 1'b1;
        end
        default: begin
          TDO    <= 1'b0;
          TDO_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule
